imgproc_pipe: RTL

//  Parametrised grayscale 3x3 image-processing pipeline. Sits between RAW2GRAY and the display/SDRAM path.

---
 rtl/imgproc_pkg.sv | 20 ++
 rtl/imgproc_if.sv | 31 +++
 rtl/imgproc_pipe_line_buffer_3x3.sv | 47 ++++
 rtl/imgproc_pipe.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/imgproc_pkg.sv
// Shared types and constants for the 3x3 grayscale image pipeline.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package imgproc_pkg;

  typedef enum logic [1:0] {MODE_GRAY, MODE_BLUR, MODE_SOBEL, MODE_EDGE} mode_t;
  typedef enum logic {UNARMED, RUN} state_t;

  // Accept-to-oDVAL delay in cycles: window, kernel sums, final mux.
  localparam int LAT = 3;

  // Gaussian result is the weighted sum divided by 16.
  localparam int GAUSS_NORM = 4;

  // 1-2-1 smoothing taps expressed as left-shift amounts. The Gaussian weight
  // of tap (r,c) is 2^(TAP_SH[r]+TAP_SH[c]); the Sobel cross-axis weight is
  // 2^TAP_SH[k].
  localparam logic [1:0] TAP_SH [3] = '{2'd0, 2'd1, 2'd0};

endpackage

// File: rtl/imgproc_if.sv
// Pixel stream in and RGB result out of the image pipeline.
// Latency: not applicable (wiring only).
// Backpressure: none; the stream is valid-only.
interface imgproc_if
  import imgproc_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int COORD_W = 16
);
  logic [DATA_W-1:0]  iDATA;
  logic               iDVAL;
  logic [COORD_W-1:0] iX_Cont;
  logic [COORD_W-1:0] iY_Cont;
  mode_t              iMODE;
  logic [DATA_W-1:0]  iTHRESH;
  logic [DATA_W-1:0]  oRed;
  logic [DATA_W-1:0]  oGreen;
  logic [DATA_W-1:0]  oBlue;
  logic               oDVAL;
  logic               oFSTART;

  modport master (
    output iDATA, iDVAL, iX_Cont, iY_Cont, iMODE, iTHRESH,
    input  oRed, oGreen, oBlue, oDVAL, oFSTART
  );

  modport slave (
    input  iDATA, iDVAL, iX_Cont, iY_Cont, iMODE, iTHRESH,
    output oRed, oGreen, oBlue, oDVAL, oFSTART
  );
endinterface

// File: rtl/imgproc_pipe_line_buffer_3x3.sv
// Two row RAMs plus a 3x3 window; win[r][c], r=0 is two rows up, c=0 is two columns left.
// Latency: window and winVld register one cycle after wrEn.
// Backpressure: none; advances only when wrEn is high.
module line_buffer_3x3 #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 640,
  parameter int AW     = $clog2(IMG_W)
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         wrEn,
  input  logic [AW-1:0]                wrAddr,
  input  logic [DATA_W-1:0]            pixIn,
  output logic [2:0][2:0][DATA_W-1:0]  win,
  output logic                         winVld
);

  logic [DATA_W-1:0] rowPrev [IMG_W];
  logic [DATA_W-1:0] rowOld  [IMG_W];
  logic [DATA_W-1:0] rdPrev;
  logic [DATA_W-1:0] rdOld;

  assign rdPrev = rowPrev[wrAddr];
  assign rdOld  = rowOld[wrAddr];

  // Push the new pixel into the column at wrAddr and slide the window left.
  always_ff @(posedge iCLK) begin
    if (wrEn) begin
      rowPrev[wrAddr] <= pixIn;
      rowOld[wrAddr]  <= rdPrev;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= rdOld;
      win[1][2] <= rdPrev;
      win[2][2] <= pixIn;
    end
  end

  // Window-valid strobe follows each write by one cycle.
  always_ff @(posedge iCLK) begin
    if (iRST) winVld <= 1'b0;
    else      winVld <= wrEn;
  end

endmodule

// File: rtl/imgproc_pipe.sv
// 3x3 grayscale pipeline: gray pass-through, Gaussian blur, Sobel magnitude, binary edge.
// Latency: 3 cycles from accepted pixel to oDVAL, one result per accepted pixel.
// Backpressure: none; out-of-range coordinates are dropped.
module imgproc_pipe
  import imgproc_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int COORD_W = 16
) (
  input  logic      iCLK,
  input  logic      iRST,
  imgproc_if.slave  bus
);

  localparam int ACC_W = DATA_W + 4;
  localparam int AW    = $clog2(IMG_W);

  logic accept, origin;
  state_t state, stateNext;
  mode_t  modeQ, pixMode;

  logic [2:0][2:0][DATA_W-1:0] win;
  logic winVld;

  logic  s1Border, s1Fst;
  mode_t s1Mode;

  logic [ACC_W-1:0] blurSum, gx, gy;

  logic              s2Vld, s2Border, s2Fst;
  mode_t             s2Mode;
  logic [ACC_W-1:0]  s2Blur, s2Gx, s2Gy;
  logic [DATA_W-1:0] s2Centre, s2Thresh;

  logic [ACC_W-1:0]  absGx, absGy, mag;
  logic [DATA_W-1:0] magSat, result;

  // Reset beats a simultaneous (0,0) so a frame start is never half-taken.
  assign origin = (bus.iX_Cont == '0) && (bus.iY_Cont == '0);
  assign accept = bus.iDVAL && !iRST
                && (bus.iX_Cont < COORD_W'(IMG_W))
                && (bus.iY_Cont < COORD_W'(IMG_H));

  // State and per-frame mode registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= UNARMED;
      modeQ <= MODE_GRAY;
    end else begin
      state <= stateNext;
      if (accept && origin) modeQ <= bus.iMODE;
    end
  end

  // Arm on the first frame start; the (0,0) pixel already uses the new mode.
  always_comb begin
    stateNext = state;
    pixMode   = modeQ;
    if (accept && origin) begin
      stateNext = RUN;
      pixMode   = bus.iMODE;
    end
  end

  line_buffer_3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(AW)) u_lineBuf (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .wrEn   (accept),
    .wrAddr (bus.iX_Cont[AW-1:0]),
    .pixIn  (bus.iDATA),
    .win    (win),
    .winVld (winVld)
  );

  // Side-band that travels with the window: mode, border blanking, frame start.
  always_ff @(posedge iCLK) begin
    if (accept) begin
      s1Mode   <= pixMode;
      s1Border <= (bus.iX_Cont < COORD_W'(2)) || (bus.iY_Cont < COORD_W'(2))
                  || (state == UNARMED);
      s1Fst    <= origin;
    end
  end

  // Weighted sums; Gx is right minus left, Gy bottom minus top, modulo 2^ACC_W.
  always_comb begin
    blurSum = '0;
    gx      = '0;
    gy      = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        blurSum = blurSum + (ACC_W'(win[r][c]) << (TAP_SH[r] + TAP_SH[c]));
      end
    end
    for (int k = 0; k < 3; k++) begin
      gx = gx + (ACC_W'(win[k][2]) << TAP_SH[k]) - (ACC_W'(win[k][0]) << TAP_SH[k]);
      gy = gy + (ACC_W'(win[2][k]) << TAP_SH[k]) - (ACC_W'(win[0][k]) << TAP_SH[k]);
    end
  end

  // Stage-2 register: kernel sums, centre pixel and the live threshold.
  always_ff @(posedge iCLK) begin
    if (iRST) s2Vld <= 1'b0;
    else      s2Vld <= winVld;
    s2Blur   <= blurSum;
    s2Gx     <= gx;
    s2Gy     <= gy;
    s2Centre <= win[1][1];
    s2Thresh <= bus.iTHRESH;
    s2Mode   <= s1Mode;
    s2Border <= s1Border;
    s2Fst    <= s1Fst;
  end

  // Magnitude, saturation, threshold and mode select; borders are forced to 0.
  always_comb begin
    absGx  = s2Gx[ACC_W-1] ? -s2Gx : s2Gx;
    absGy  = s2Gy[ACC_W-1] ? -s2Gy : s2Gy;
    mag    = absGx + absGy;
    magSat = (|mag[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    result = '0;
    case (s2Mode)
      MODE_GRAY:  result = s2Centre;
      MODE_BLUR:  result = s2Blur[GAUSS_NORM +: DATA_W];
      MODE_SOBEL: result = magSat;
      MODE_EDGE:  result = (magSat >= s2Thresh) ? {DATA_W{1'b1}} : '0;
      default:    result = '0;
    endcase
    if (s2Border) result = '0;
  end

  // Registered outputs; the colour channels carry the same value.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      bus.oRed    <= '0;
      bus.oGreen  <= '0;
      bus.oBlue   <= '0;
      bus.oDVAL   <= 1'b0;
      bus.oFSTART <= 1'b0;
    end else begin
      bus.oDVAL   <= s2Vld;
      bus.oFSTART <= s2Vld && s2Fst;
      if (s2Vld) begin
        bus.oRed   <= result;
        bus.oGreen <= result;
        bus.oBlue  <= result;
      end
    end
  end

endmodule
